matmul_result_drain: RTL and testbench

MATMUL_RESULT_DRAIN -- requirements
Module: matmul_result_drain

---
 rtl/matmul_pkg.sv | 19 +
 rtl/drain_skid_fifo.sv | 68 ++++++
 rtl/matmul_result_drain.sv | 169 ++++++++++++++++
 tb/tb_matmul_result_drain.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared matmul definitions: default widths, the drain FSM state encoding
// and a small width helper. Used by tiled_matmul_engine and its result drain.
package matmul_pkg;

  localparam int ACC_WIDTH_DEF  = 32;
  localparam int MATRIX_DIM_DEF = 16;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_RUN   = 2'd1,
    DRAIN_FLUSH = 2'd2
  } drain_state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/drain_skid_fifo.sv
// Two-entry FIFO between the result memory read port and the output stream.
// The head entry is a register that drives the stream directly, so the
// output word stays put while the consumer stalls.
module drain_skid_fifo
  import matmul_pkg::*;
#(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_reg, head_next;
  logic [WIDTH-1:0] tail_reg, tail_next;
  logic [1:0]       count_reg, count_next;

  // Next-state of the two entries; the head only changes on pop or on a push
  // into an empty FIFO, which keeps the stalled output stable.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    case ({push, pop})
      2'b10: begin
        if (count_reg == 2'd0) head_next = push_data;
        else                   tail_next = push_data;
        count_next = count_reg + 2'd1;
      end
      2'b01: begin
        if (count_reg == 2'd2) head_next = tail_reg;
        count_next = count_reg - 2'd1;
      end
      2'b11: begin
        if (count_reg == 2'd1) begin
          head_next = push_data;
        end else begin
          head_next = tail_reg;
          tail_next = push_data;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers; reset empties the FIFO and zeroes the head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 2'd0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign head_data  = head_reg;
  assign head_valid = (count_reg != 2'd0);
  assign count      = count_reg;

endmodule

// File: rtl/matmul_result_drain.sv
// Drains a MATRIX_DIM x MATRIX_DIM accumulator result memory in row-major
// order onto a valid/ready stream, with row and matrix end markers.
// Optional build macro RESULT_CHECKSUM_EN adds a running checksum output.
module matmul_result_drain
  import matmul_pkg::*;
#(
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int MATRIX_DIM = MATRIX_DIM_DEF,
  localparam int SIZE      = MATRIX_DIM * MATRIX_DIM,
  localparam int ADDR_W    = clog2_min1(SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic [ACC_WIDTH-1:0] mem_rd_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ACC_WIDTH-1:0] m_data,
  output logic                 m_row_last,
  output logic                 m_last
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [ACC_WIDTH-1:0] checksum,
  output logic                 checksum_valid
`endif
);

  localparam int COL_W  = clog2_min1(MATRIX_DIM);
  localparam int FIFO_W = ACC_WIDTH + 2;

  drain_state_e     state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [COL_W-1:0]  col_reg, col_next;
  logic              done_reg, done_next;

  // Read issued last cycle: its data is on mem_rd_data this cycle.
  logic              in_flight_reg;
  logic              in_flight_row_last_reg;
  logic              in_flight_last_reg;

  logic [FIFO_W-1:0] fifo_head;
  logic              fifo_valid;
  logic [1:0]        fifo_count;
  logic [1:0]        occupancy;
  logic              pop;
  logic              rd_en;
  logic              addr_is_last;
  logic              col_is_last;

  assign pop          = fifo_valid && m_ready;
  assign addr_is_last = (addr_reg == ADDR_W'(SIZE - 1));
  assign col_is_last  = (col_reg == COL_W'(MATRIX_DIM - 1));

  // Words that will sit in the FIFO once this cycle's pop and returning data
  // settle; a new read is only safe while that stays below two, and counting
  // the pop lets the stream sustain one word per cycle.
  assign occupancy = fifo_count - 2'(pop) + 2'(in_flight_reg);
  assign rd_en     = (state_reg == DRAIN_RUN) && (occupancy < 2'd2);

  // FSM next state, address/column counters and done pulse.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    col_next   = col_reg;
    done_next  = 1'b0;
    case (state_reg)
      DRAIN_IDLE: begin
        if (start) begin
          state_next = DRAIN_RUN;
          addr_next  = '0;
          col_next   = '0;
        end
      end
      DRAIN_RUN: begin
        if (rd_en) begin
          if (addr_is_last) begin
            // Address parks on the final word instead of wrapping.
            state_next = DRAIN_FLUSH;
          end else begin
            addr_next = addr_reg + ADDR_W'(1);
            col_next  = col_is_last ? '0 : col_reg + COL_W'(1);
          end
        end
      end
      DRAIN_FLUSH: begin
        if (pop && fifo_head[FIFO_W-2]) begin
          state_next = DRAIN_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = DRAIN_IDLE;
    endcase
  end

  // State, counters and done register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= DRAIN_IDLE;
      addr_reg  <= '0;
      col_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      col_reg   <= col_next;
      done_reg  <= done_next;
    end
  end

  // Tag each outstanding read with its markers; reset drops in-flight data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight_reg          <= 1'b0;
      in_flight_row_last_reg <= 1'b0;
      in_flight_last_reg     <= 1'b0;
    end else begin
      in_flight_reg          <= rd_en;
      in_flight_row_last_reg <= rd_en && col_is_last;
      in_flight_last_reg     <= rd_en && addr_is_last;
    end
  end

  drain_skid_fifo #(
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight_reg),
    .push_data ({in_flight_row_last_reg, in_flight_last_reg, mem_rd_data}),
    .pop       (pop),
    .head_data (fifo_head),
    .head_valid(fifo_valid),
    .count     (fifo_count)
  );

  assign busy        = (state_reg != DRAIN_IDLE);
  assign done        = done_reg;
  assign mem_rd_en   = rd_en;
  assign mem_rd_addr = addr_reg;
  assign m_valid     = fifo_valid;
  assign m_data      = fifo_head[ACC_WIDTH-1:0];
  assign m_last      = fifo_head[FIFO_W-2];
  assign m_row_last  = fifo_head[FIFO_W-1];

`ifdef RESULT_CHECKSUM_EN
  logic [ACC_WIDTH-1:0] checksum_reg;

  // Running modulo-2^ACC_WIDTH sum of delivered words, restarted per drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_reg <= '0;
    end else if ((state_reg == DRAIN_IDLE) && start) begin
      checksum_reg <= '0;
    end else if (pop) begin
      checksum_reg <= checksum_reg + fifo_head[ACC_WIDTH-1:0];
    end
  end

  assign checksum       = checksum_reg;
  assign checksum_valid = done_reg;
`else
  // Checksum feature not built.
`endif

endmodule

// File: tb/tb_matmul_result_drain.sv
// Directed bench for matmul_result_drain at MATRIX_DIM=4: a cycle table for
// the plain drain plus hand-written stall, restart, reset and back-to-back
// sequences. Define RESULT_CHECKSUM_EN to also exercise the checksum.
module tb_matmul_result_drain;

  localparam int AW   = 32;
  localparam int DIM  = 4;
  localparam int SIZE = DIM * DIM;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, mem_rd_en;
  logic [3:0]    mem_rd_addr;
  logic [AW-1:0] mem_rd_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW-1:0] m_data;
  logic          m_row_last, m_last;
`ifdef RESULT_CHECKSUM_EN
  logic [AW-1:0] checksum;
  logic          checksum_valid;
`endif

  matmul_result_drain #(.ACC_WIDTH(AW), .MATRIX_DIM(DIM)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_row_last (m_row_last),
    .m_last     (m_last)
`ifdef RESULT_CHECKSUM_EN
    ,
    .checksum      (checksum),
    .checksum_valid(checksum_valid)
`endif
  );

  always #5 clk = ~clk;

  // Result memory model: one-cycle read latency.
  logic [AW-1:0] mem [SIZE];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] data;
    logic          rl;
    logic          last;
    int            cyc;
  } rx_t;
  rx_t         rx_q[$];
  int          done_cnt = 0;
  int          cyc = 0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_word = '0;

  function automatic logic [33:0] pack_word(logic rl, logic last, logic [AW-1:0] d);
    return {rl, last, d};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Mid-cycle monitor: collects handshaken words, counts done pulses and
  // checks the head holds still across every stalled cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!m_valid || pack_word(m_row_last, m_last, m_data) !== prev_word) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b w=%h required v=1 w=%h",
                   m_valid, pack_word(m_row_last, m_last, m_data), prev_word);
        end
      end
      if (m_valid && m_ready) rx_q.push_back('{m_data, m_row_last, m_last, cyc});
      if (done) done_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_word  = pack_word(m_row_last, m_last, m_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 400) begin
      step();
      n++;
    end
    check(name, done, 1'b1);
  endtask

  // Compare collected words against n_drains copies of base+k, k=0..SIZE-1.
  task automatic check_stream(input string name, input logic [AW-1:0] base, input int n_drains);
    check({name, "_count"}, rx_q.size(), SIZE * n_drains);
    for (int i = 0; i < rx_q.size() && i < SIZE * n_drains; i++) begin
      int k = i % SIZE;
      check($sformatf("%s_word%0d", name, i),
            pack_word(rx_q[i].rl, rx_q[i].last, rx_q[i].data),
            pack_word((k % DIM) == DIM - 1, k == SIZE - 1, base + AW'(k)));
    end
  endtask

  task automatic fill_mem(input logic [AW-1:0] base);
    for (int k = 0; k < SIZE; k++) mem[k] = base + AW'(k);
  endtask

  typedef struct {
    logic          ready;
    logic          valid;
    logic [AW-1:0] data;
    logic          rl;
    logic          last;
    logic          done;
    logic          busy;
  } vec_t;
  vec_t vecs[20];

  initial begin
    // Cycle c is observed just after the c-th edge following the start edge.
    for (int c = 0; c < 20; c++) begin
      vecs[c].ready = 1'b1;
      vecs[c].valid = (c >= 2) && (c <= 17);
      vecs[c].data  = vecs[c].valid ? AW'(c - 2) : '0;
      vecs[c].rl    = vecs[c].valid && (((c - 2) % DIM) == DIM - 1);
      vecs[c].last  = (c == 17);
      vecs[c].done  = (c == 18);
      vecs[c].busy  = (c < 18);
    end

    fill_mem('0);

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b0;
    #1;
    check("reset_outputs",
          {busy, done, mem_rd_en, mem_rd_addr, m_valid, m_data, m_row_last, m_last},
          '0);
`ifdef RESULT_CHECKSUM_EN
    check("reset_checksum", {checksum_valid, checksum}, '0);
`endif
    step();
    step();
    rst = 1'b1;
    step();

    // Plain drain, full rate, cycle by cycle.
    rx_q.delete();
    done_cnt = 0;
    m_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 20; c++) begin
      m_ready = vecs[c].ready;
      check($sformatf("table_c%0d", c),
            {m_valid, m_valid ? pack_word(m_row_last, m_last, m_data) : 34'd0, done, busy},
            {vecs[c].valid,
             vecs[c].valid ? pack_word(vecs[c].rl, vecs[c].last, vecs[c].data) : 34'd0,
             vecs[c].done, vecs[c].busy});
      step();
    end
    check_stream("plain", '0, 1);
    check("plain_done_cnt", done_cnt, 1);

    // Toggling ready, then a five-cycle stall on word 6.
    begin
      int   held = 0;
      logic tog = 1'b1;
      rx_q.delete();
      done_cnt = 0;
      m_ready = 1'b0;
      pulse_start();
      for (int n = 0; n < 300 && done_cnt == 0; n++) begin
        if (rx_q.size() == 6 && held < 5) begin
          m_ready = 1'b0;
          held++;
          if (held == 5) begin
            step();
            check("held_word6", {m_valid, m_data}, {1'b1, AW'(6)});
            continue;
          end
        end else begin
          m_ready = tog;
          tog = ~tog;
        end
        step();
      end
      m_ready = 1'b1;
      step();
      check_stream("stall", '0, 1);
      check("stall_done_cnt", done_cnt, 1);
    end

    // Second start mid-drain is ignored.
    begin
      logic again = 1'b0;
      rx_q.delete();
      done_cnt = 0;
      m_ready = 1'b1;
      pulse_start();
      for (int n = 0; n < 100 && done_cnt == 0; n++) begin
        if (rx_q.size() == 5 && !again) begin
          start = 1'b1;
          again = 1'b1;
        end else begin
          start = 1'b0;
        end
        step();
      end
      start = 1'b0;
      repeat (10) step();
      check_stream("restart_ignored", '0, 1);
      check("restart_done_cnt", done_cnt, 1);
      check("restart_idle_busy", busy, 1'b0);
    end

    // Reset asserted mid-cycle at word 9, then a fresh drain.
    begin
      int n = 0;
      rx_q.delete();
      done_cnt = 0;
      m_ready = 1'b1;
      pulse_start();
      while (rx_q.size() < 9 && n < 100) begin
        step();
        n++;
      end
      check("reached_word9", {m_valid, m_data}, {1'b1, AW'(9)});
      #3 rst = 1'b0;
      #1;
      check("async_reset_outputs",
            {busy, done, mem_rd_en, mem_rd_addr, m_valid, m_data, m_row_last, m_last},
            '0);
      step();
      step();
      rst = 1'b1;
      rx_q.delete();
      repeat (4) step();
      check("post_reset_quiet", {rx_q.size(), busy, m_valid}, '0);
      done_cnt = 0;
      pulse_start();
      wait_done("post_reset_done");
      step();
      check_stream("post_reset", '0, 1);
      check("post_reset_done_cnt", done_cnt, 1);
    end

    // Back-to-back drains: start asserted in the done cycle.
    rx_q.delete();
    done_cnt = 0;
    m_ready = 1'b1;
    pulse_start();
    wait_done("b2b_first_done");
    start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_lat0", {busy, m_valid}, 2'b10);
    step();
    check("b2b_lat1", {busy, m_valid}, 2'b10);
    step();
    check("b2b_first_word", {m_valid, m_data}, {1'b1, AW'(0)});
    wait_done("b2b_second_done");
    step();
    check_stream("b2b", '0, 2);
    check("b2b_done_cnt", done_cnt, 2);
    if (rx_q.size() == 2 * SIZE) begin
      check("b2b_gap", rx_q[SIZE].cyc - rx_q[SIZE-1].cyc, 4);
      check("b2b_second_span", rx_q[2*SIZE-1].cyc - rx_q[SIZE].cyc, SIZE - 1);
    end

`ifdef RESULT_CHECKSUM_EN
    // Checksum wraps modulo 2^32.
    fill_mem(32'hFFFF_FFF0);
    rx_q.delete();
    done_cnt = 0;
    m_ready = 1'b1;
    pulse_start();
    wait_done("csum_done");
    check("csum_value", {checksum_valid, checksum}, {1'b1, 32'hFFFF_FF78});
    step();
    check("csum_valid_pulse", checksum_valid, 1'b0);
    check_stream("csum", 32'hFFFF_FFF0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
